gsim_ctrl: RTL and testbench

GSIM_CTRL -- requirements
Module: gsim_ctrl

---
 rtl/gsim_ctrl_if.sv | 36 +++
 rtl/gsim_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gsim_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsim_ctrl_if.sv
// Handshake bundle between the Gauss-Seidel sequencer, its load/unload
// environment and the external x[i] update datapath.
interface gsim_ctrl_if;
  logic        in_en;
  logic [15:0] b_in;
  logic        dp_start;
  logic [3:0]  dp_idx;
  logic [15:0] dp_b;
  logic [31:0] dp_xm1;
  logic [31:0] dp_xm2;
  logic [31:0] dp_xm3;
  logic [31:0] dp_xp1;
  logic [31:0] dp_xp2;
  logic [31:0] dp_xp3;
  logic        dp_done;
  logic [31:0] dp_x;
  logic        busy;
  logic        out_valid;
  logic [31:0] x_out;

  // Controller side
  modport slave (
    input  in_en, b_in, dp_done, dp_x,
    output dp_start, dp_idx, dp_b,
    output dp_xm1, dp_xm2, dp_xm3, dp_xp1, dp_xp2, dp_xp3,
    output busy, out_valid, x_out
  );

  // Environment side: loader, datapath and result consumer
  modport master (
    output in_en, b_in, dp_done, dp_x,
    input  dp_start, dp_idx, dp_b,
    input  dp_xm1, dp_xm2, dp_xm3, dp_xp1, dp_xp2, dp_xp3,
    input  busy, out_valid, x_out
  );
endinterface

// File: rtl/gsim_ctrl.sv
// Sequencer for an in-place Gauss-Seidel solve of a banded (+/-3) system:
// loads b[], issues one datapath request per unknown per sweep, streams x[].
module gsim_ctrl #(
  parameter int N_EQ   = 16,
  parameter int N_ITER = 64
) (
  input logic       clk,
  input logic       reset,
  gsim_ctrl_if.slave bus
);

  localparam int IW = $clog2(N_EQ);

  typedef logic [IW-1:0] idx_t;

  localparam idx_t       LAST_IDX   = idx_t'(N_EQ - 1);
  localparam logic [7:0] LAST_SWEEP = 8'(N_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_e;

  state_e     state_q, state_d;
  idx_t       cnt_q, cnt_d;      // load count in LOAD, output index k in OUT
  idx_t       idx_q, idx_d;
  logic [7:0] sweep_q, sweep_d;

  logic        b_we;
  idx_t        b_waddr;
  logic        x_clr;
  logic        x_we;
  logic [15:0] b_q [N_EQ];
  logic [31:0] x_q [N_EQ];

  // NOTE: non-blocking assignments for every flop so all registers update
  // together on the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sweep_q <= sweep_d;
    end
  end

  // NOTE: the b[]/x[] stores are reset explicitly because an abandoned
  // problem must not leak stale values onto dp_b or the neighbour outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_EQ; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      if (b_we) b_q[b_waddr] <= bus.b_in;
      if (x_clr) begin
        for (int i = 0; i < N_EQ; i++) x_q[i] <= '0;
      end else if (x_we) begin
        x_q[idx_q] <= bus.dp_x;
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sweep_d = sweep_q;
    b_we    = 1'b0;
    b_waddr = cnt_q;
    x_clr   = 1'b0;
    x_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_en) begin
          b_we    = 1'b1;
          b_waddr = '0;
          x_clr   = 1'b1;
          sweep_d = '0;
          idx_d   = '0;
          cnt_d   = idx_t'(1);
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (bus.in_en) begin
          b_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + idx_t'(1);
          end
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (bus.dp_done) begin
          x_we = 1'b1;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + idx_t'(1);
            state_d = S_ISSUE;
          end else if (sweep_q < LAST_SWEEP) begin
            sweep_d = sweep_q + 8'd1;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + idx_t'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Band neighbours read straight from x[]: lower indices already hold this
  // sweep's results, which is what makes the update Gauss-Seidel.
  logic [31:0] xm [3];
  logic [31:0] xp [3];

  for (genvar d = 1; d <= 3; d++) begin : g_nb
    localparam idx_t D = idx_t'(d);
    assign xm[d-1] = (idx_q >= D)            ? x_q[idx_q - D] : '0;
    assign xp[d-1] = (idx_q <= LAST_IDX - D) ? x_q[idx_q + D] : '0;
  end

  assign bus.dp_xm1 = xm[0];
  assign bus.dp_xm2 = xm[1];
  assign bus.dp_xm3 = xm[2];
  assign bus.dp_xp1 = xp[0];
  assign bus.dp_xp2 = xp[1];
  assign bus.dp_xp3 = xp[2];

  assign bus.dp_start  = (state_q == S_ISSUE);
  assign bus.dp_idx    = idx_q;
  assign bus.dp_b      = b_q[idx_q];
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.x_out     = (state_q == S_OUT) ? x_q[cnt_q] : '0;

endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed bench for gsim_ctrl: one instance with a single sweep, one with
// two sweeps, each served by a fixed-latency stub datapath x[i] = i << 16.
module tb_gsim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_en;
  logic [15:0] b_in;
  logic        man_done;
  logic        sel;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  gsim_ctrl_if ifa ();
  gsim_ctrl_if ifb ();

  gsim_ctrl #(.N_EQ(16), .N_ITER(1)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
  gsim_ctrl #(.N_EQ(16), .N_ITER(2)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

  // Stub datapath: result strobe 3 cycles after dp_start
  logic [2:0] sr_a, sr_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_a <= '0;
      sr_b <= '0;
    end else begin
      sr_a <= {sr_a[1:0], ifa.dp_start};
      sr_b <= {sr_b[1:0], ifb.dp_start};
    end
  end

  assign ifa.in_en   = in_en & ~sel;
  assign ifa.b_in    = b_in;
  assign ifa.dp_done = sr_a[2] | (man_done & ~sel);
  assign ifa.dp_x    = {12'h0, ifa.dp_idx, 16'h0};
  assign ifb.in_en   = in_en & sel;
  assign ifb.b_in    = b_in;
  assign ifb.dp_done = sr_b[2] | (man_done & sel);
  assign ifb.dp_x    = {12'h0, ifb.dp_idx, 16'h0};

  logic        mon_start, mon_busy, mon_valid;
  logic [3:0]  mon_idx;
  logic [15:0] mon_b;
  logic [31:0] mon_xm1, mon_xm2, mon_xm3, mon_xp1, mon_xp2, mon_xp3, mon_x;

  assign mon_start = sel ? ifb.dp_start  : ifa.dp_start;
  assign mon_busy  = sel ? ifb.busy      : ifa.busy;
  assign mon_valid = sel ? ifb.out_valid : ifa.out_valid;
  assign mon_idx   = sel ? ifb.dp_idx    : ifa.dp_idx;
  assign mon_b     = sel ? ifb.dp_b      : ifa.dp_b;
  assign mon_xm1   = sel ? ifb.dp_xm1    : ifa.dp_xm1;
  assign mon_xm2   = sel ? ifb.dp_xm2    : ifa.dp_xm2;
  assign mon_xm3   = sel ? ifb.dp_xm3    : ifa.dp_xm3;
  assign mon_xp1   = sel ? ifb.dp_xp1    : ifa.dp_xp1;
  assign mon_xp2   = sel ? ifb.dp_xp2    : ifa.dp_xp2;
  assign mon_xp3   = sel ? ifb.dp_xp3    : ifa.dp_xp3;
  assign mon_x     = sel ? ifb.x_out     : ifa.x_out;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mon_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_start_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic load(input logic [15:0] base, input int pause_at,
                      input int pause_len, input logic pulse);
    for (int i = 0; i < 16; i++) begin
      if (i == pause_at) begin
        in_en    = 1'b0;
        man_done = pulse;
        for (int c = 0; c < pause_len; c++) step();
        man_done = 1'b0;
        check("busy_in_pause", 32'(mon_busy), 32'd1);
        check("no_start_in_pause", 32'(mon_start), 32'd0);
      end
      in_en = 1'b1;
      b_in  = base + 16'(i);
      step();
      if (i == 0) check("busy_after_first_word", 32'(mon_busy), 32'd1);
    end
    in_en = 1'b0;
    check("first_start_after_load", 32'(mon_start), 32'd1);
  endtask

  task automatic run_sweeps(input int sweeps, input logic [15:0] base);
    int   i;
    int   extra;
    logic ok;
    for (int p = 0; p < 16 * sweeps; p++) begin
      i = p % 16;
      wait_start("sweep");
      check($sformatf("dp_idx_p%0d", p), 32'(mon_idx), 32'(i));
      check($sformatf("dp_b_p%0d", p), 32'(mon_b), 32'(base + 16'(i)));
      if (p == 0) begin
        check("first_xm1", mon_xm1, 32'h0);
        check("first_xp1", mon_xp1, 32'h0);
      end
      if (sweeps == 2 && p == 16) begin
        check("s2_i0_xm1", mon_xm1, 32'h0);
        check("s2_i0_xm2", mon_xm2, 32'h0);
        check("s2_i0_xm3", mon_xm3, 32'h0);
        check("s2_i0_xp1", mon_xp1, 32'h0001_0000);
        check("s2_i0_xp2", mon_xp2, 32'h0002_0000);
        check("s2_i0_xp3", mon_xp3, 32'h0003_0000);
      end
      if (sweeps == 2 && p == 31) begin
        check("s2_i15_xm1", mon_xm1, 32'h000E_0000);
        check("s2_i15_xm3", mon_xm3, 32'h000C_0000);
        check("s2_i15_xp1", mon_xp1, 32'h0);
        check("s2_i15_xp2", mon_xp2, 32'h0);
        check("s2_i15_xp3", mon_xp3, 32'h0);
      end
      step();
      if (p == 3) begin
        check("start_one_cycle", 32'(mon_start), 32'd0);
        check("idx_stable_wait", 32'(mon_idx), 32'd3);
        check("b_stable_wait", 32'(mon_b), 32'(base + 16'd3));
      end
    end
    ok    = 1'b0;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      if (mon_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (mon_start === 1'b1) extra++;
      step();
    end
    check("out_valid_timeout", 32'(ok), 32'd1);
    check("extra_dp_start", 32'(extra), 32'd0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("out_valid_k%0d", k), 32'(mon_valid), 32'd1);
      check($sformatf("x_out_k%0d", k), mon_x, 32'(k) << 16);
      step();
    end
    check("out_valid_after", 32'(mon_valid), 32'd0);
    check("x_out_after", mon_x, 32'h0);
    check("busy_after_out", 32'(mon_busy), 32'd0);
  endtask

  int stray;

  initial begin
    sel      = 1'b0;
    in_en    = 1'b1;
    b_in     = 16'h1234;
    man_done = 1'b0;
    rst_n    = 1'b0;

    // Reset held with in_en active
    repeat (3) step();
    check("rst_a_start", 32'(mon_start), 32'd0);
    check("rst_a_busy", 32'(mon_busy), 32'd0);
    check("rst_a_valid", 32'(mon_valid), 32'd0);
    check("rst_a_idx", 32'(mon_idx), 32'd0);
    check("rst_a_b", 32'(mon_b), 32'd0);
    check("rst_a_xp1", mon_xp1, 32'h0);
    check("rst_a_x_out", mon_x, 32'h0);
    sel = 1'b1;
    #1;
    check("rst_b_busy", 32'(mon_busy), 32'd0);
    check("rst_b_valid", 32'(mon_valid), 32'd0);
    sel   = 1'b0;
    in_en = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(mon_busy), 32'd0);
    check("post_rst_b0", 32'(mon_b), 32'd0);

    // Single sweep, contiguous load
    load(16'h0000, 16, 0, 1'b0);
    run_sweeps(1, 16'h0000);

    // Back-to-back problem with a 5-cycle pause in the middle of the load
    load(16'h0100, 8, 5, 1'b0);
    run_sweeps(1, 16'h0100);

    // Two sweeps: neighbour values across the sweep boundary
    sel = 1'b1;
    #1;
    load(16'h0000, 16, 0, 1'b0);
    run_sweeps(2, 16'h0000);

    // Stray dp_done in IDLE, LOAD and the dp_start cycle
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("idle_done_busy", 32'(mon_busy), 32'd0);
    check("idle_done_start", 32'(mon_start), 32'd0);
    load(16'h0200, 4, 2, 1'b1);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("issue_done_start", 32'(mon_start), 32'd0);
    check("issue_done_idx", 32'(mon_idx), 32'd0);
    step();
    check("issue_done_start2", 32'(mon_start), 32'd0);
    check("issue_done_idx2", 32'(mon_idx), 32'd0);
    for (int p = 1; p <= 5; p++) begin
      wait_start("abort");
      check($sformatf("abort_idx_p%0d", p), 32'(mon_idx), 32'(p));
      check($sformatf("abort_b_p%0d", p), 32'(mon_b), 32'(16'h0200 + 16'(p)));
      step();
    end
    check("wait5_xm1", mon_xm1, 32'h0004_0000);

    // Reset in the middle of WAIT
    rst_n = 1'b0;
    in_en = 1'b1;
    b_in  = 16'h7777;
    #1;
    check("midrst_busy", 32'(mon_busy), 32'd0);
    check("midrst_start", 32'(mon_start), 32'd0);
    check("midrst_valid", 32'(mon_valid), 32'd0);
    check("midrst_idx", 32'(mon_idx), 32'd0);
    check("midrst_b", 32'(mon_b), 32'd0);
    check("midrst_xp1", mon_xp1, 32'h0);
    check("midrst_x_out", mon_x, 32'h0);
    repeat (3) step();
    in_en = 1'b0;
    rst_n = 1'b1;
    step();
    check("rel_busy", 32'(mon_busy), 32'd0);
    check("rel_b0", 32'(mon_b), 32'd0);
    check("rel_xp1", mon_xp1, 32'h0);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      if (mon_start !== 1'b0 || mon_valid !== 1'b0 || mon_busy !== 1'b0) stray++;
      step();
    end
    check("no_pulse_after_reset", 32'(stray), 32'd0);

    load(16'h0000, 16, 0, 1'b0);
    run_sweeps(2, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
